mdio_master_ctrl: RTL

MDIO (IEEE 802.3 Clause 22) management master for the MAC. Accepts one register read/write request at a time over a valid/ready interface, generates MDC from the system clock, and serialises preamble, start, opcode, PHY address, register address, turnaround and data onto MDIO. Read data and completion are returned on a one-cycle response strobe. MDIO is exposed as split out/oe/in pins; the top level builds the tristate.

---
 rtl/mdio_master_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mdio_master_ctrl.sv
// Clause 22 MDIO master: serialises one read/write frame per accepted request on split out/oe pins.
// Latency: accept -> resp_valid = 1 + (PREAMBLE_LEN+33)*2*CLK_DIV clk cycles; req_ready low while busy.
module mdio_master_ctrl #(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy_addr,
  input  logic [4:0]  req_reg_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in
);

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_HEADER, S_TA, S_DATA, S_END} state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] PRE_LAST = 6'((PREAMBLE_LEN == 0) ? 0 : PREAMBLE_LEN - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        mdc_q, mdc_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] frame_q, frame_d;
  logic        write_q, write_d;
  logic [15:0] rshift_q, rshift_d;
  logic [15:0] rdata_q, rdata_d;
  logic        resp_q, resp_d;
  logic        busy_q, busy_d;
  logic        out_q, out_d;
  logic        oe_q, oe_d;
  logic        tick_term, rise, fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      mdc_q    <= 1'b0;
      bit_q    <= '0;
      frame_q  <= '0;
      write_q  <= 1'b0;
      rshift_q <= '0;
      rdata_q  <= '0;
      resp_q   <= 1'b0;
      busy_q   <= 1'b0;
      out_q    <= 1'b1;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      mdc_q    <= mdc_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      write_q  <= write_d;
      rshift_q <= rshift_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      busy_q   <= busy_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    mdc_d    = mdc_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    write_d  = write_q;
    rshift_d = rshift_q;
    rdata_d  = rdata_q;
    resp_d   = 1'b0;
    busy_d   = busy_q;
    out_d    = out_q;
    oe_d     = oe_q;

    tick_term = busy_q && (div_q == DIV_LAST);
    rise      = tick_term && !mdc_q;
    fall      = tick_term && mdc_q;

    if (state_q == S_IDLE) begin
      if (req_valid) begin
        write_d  = req_write;
        frame_d  = {2'b01, (req_write ? 2'b01 : 2'b10), req_phy_addr, req_reg_addr, 2'b10,
                    (req_write ? req_wdata : 16'h0000)};
        div_d    = '0;
        mdc_d    = 1'b0;
        bit_d    = '0;
        rshift_d = '0;
        busy_d   = 1'b1;
        oe_d     = 1'b1;
        if (PREAMBLE_LEN == 0) begin
          state_d = S_HEADER;
          out_d   = 1'b0;
        end else begin
          state_d = S_PREAMBLE;
          out_d   = 1'b1;
        end
      end
    end else if (resp_q) begin
      // Completion strobe cycle: mdc already low, release to IDLE next.
      state_d = S_IDLE;
      busy_d  = 1'b0;
      div_d   = '0;
      mdc_d   = 1'b0;
    end else begin
      if (tick_term) begin
        div_d = '0;
        mdc_d = ~mdc_q;
      end else begin
        div_d = div_q + 8'd1;
      end

      if (rise && (state_q == S_DATA) && !write_q) rshift_d = {rshift_q[14:0], mdio_in};

      // Falling tick: retire the current bit and present the next one.
      if (fall) begin
        bit_d = bit_q + 6'd1;
        case (state_q)
          S_PREAMBLE: begin
            if (bit_q == PRE_LAST) begin
              state_d = S_HEADER;
              bit_d   = '0;
              out_d   = frame_q[31];
            end
          end
          S_HEADER: begin
            frame_d = {frame_q[30:0], 1'b0};
            out_d   = frame_q[30];
            if (bit_q == 6'd13) begin
              state_d = S_TA;
              bit_d   = '0;
              oe_d    = write_q;
            end
          end
          S_TA: begin
            frame_d = {frame_q[30:0], 1'b0};
            out_d   = frame_q[30];
            if (bit_q == 6'd1) begin
              state_d = S_DATA;
              bit_d   = '0;
            end
          end
          S_DATA: begin
            frame_d = {frame_q[30:0], 1'b0};
            out_d   = frame_q[30];
            if (bit_q == 6'd15) begin
              state_d = S_END;
              bit_d   = '0;
              oe_d    = 1'b0;
              out_d   = 1'b1;
            end
          end
          S_END: begin
            resp_d = 1'b1;
            if (!write_q) rdata_d = rshift_q;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_q;
  assign resp_rdata = rdata_q;
  assign busy       = busy_q;
  assign mdc        = mdc_q;
  assign mdio_out   = out_q;
  assign mdio_oe    = oe_q;

endmodule
